// File: rtl/mem_write_monitor.sv
// ---------------------------------------------------------------------------
// mem_write_monitor
//
// Watches a memory write bus and checks that the writes arrive in the order
// held in a small expected-write table. Writes into a scratch address window
// are ignored. The check ends in PASS when every armed entry has been matched.
// It ends in FAIL on a data mismatch, an unexpected address or a timeout.
//
// Ports
//   clk        : single clock, rising edge
//   reset_n    : asynchronous active-low reset
//   cfg_we     : table write strobe (accepted outside RUN only)
//   cfg_idx    : table entry index
//   cfg_addr   : expected address for the entry
//   cfg_data   : expected data for the entry
//   cfg_count  : number of entries to check, clipped to DEPTH
//   start      : arm the monitor (ignored while in RUN)
//   memwrite   : bus write strobe (X/Z counts as no write)
//   dataadr    : bus address
//   writedata  : bus data
//   busy       : high while in RUN
//   done       : high while in PASS or FAIL
//   pass       : high while in PASS
//   fail_code  : 0 none, 1 data mismatch, 2 timeout, 3 unexpected address
//   match_cnt  : entries matched so far
//   fail_addr  : address of the write that caused FAIL
//   fail_data  : data of the write that caused FAIL
// ---------------------------------------------------------------------------
module mem_write_monitor #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 8,
    parameter int IDXW       = 3,
    parameter int TIMEOUT    = 1000,
    parameter int SCRATCH_LO = 80,
    parameter int SCRATCH_HI = 80
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_we,
    input  logic [IDXW-1:0]  cfg_idx,
    input  logic [WIDTH-1:0] cfg_addr,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic [IDXW:0]    cfg_count,
    input  logic             start,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] dataadr,
    input  logic [WIDTH-1:0] writedata,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [1:0]       fail_code,
    output logic [IDXW:0]    match_cnt,
    output logic [WIDTH-1:0] fail_addr,
    output logic [WIDTH-1:0] fail_data
);

    // Counter wide enough to hold TIMEOUT itself, so it never wraps.
    localparam int CYCW = $clog2(TIMEOUT + 1);

    localparam logic [IDXW:0]    DEPTH_C   = DEPTH[IDXW:0];
    localparam logic [CYCW-1:0]  CYC_LAST  = CYCW'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] SCR_LO    = WIDTH'(SCRATCH_LO);
    localparam logic [WIDTH-1:0] SCR_HI    = WIDTH'(SCRATCH_HI);

    localparam logic [1:0] FC_NONE  = 2'd0;
    localparam logic [1:0] FC_DATA  = 2'd1;
    localparam logic [1:0] FC_TIME  = 2'd2;
    localparam logic [1:0] FC_ADDR  = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

    state_t state_q, state_d;
    logic [IDXW:0]    count_q, count_d;
    logic [IDXW:0]    match_q, match_d;
    logic [CYCW-1:0]  cyc_q, cyc_d;
    logic [1:0]       fcode_q, fcode_d;
    logic [WIDTH-1:0] faddr_q, faddr_d;
    logic [WIDTH-1:0] fdata_q, fdata_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    logic [WIDTH-1:0] tbl_addr_q [DEPTH];
    logic [WIDTH-1:0] tbl_data_q [DEPTH];

    // Only a clean 1 is a write; X or Z on the strobe means nothing happened.
    logic wr;
    assign wr = (memwrite === 1'b1);

    // In RUN match_q is always below the latched count, which is <= DEPTH.
    logic [IDXW-1:0] cur_idx;
    logic            hit_addr, hit_data, in_scratch;
    logic [IDXW:0]   start_cnt;
    logic            cfg_ok;

    assign cur_idx    = match_q[IDXW-1:0];
    assign hit_addr   = (dataadr   == tbl_addr_q[cur_idx]);
    assign hit_data   = (writedata == tbl_data_q[cur_idx]);
    assign in_scratch = (dataadr >= SCR_LO) && (dataadr <= SCR_HI);
    assign start_cnt  = (cfg_count > DEPTH_C) ? DEPTH_C : cfg_count;
    assign cfg_ok     = (32'(cfg_idx) < DEPTH);

    // Expected-write table.
    // NOTE: the table is reset like any other register because reset must leave
    // it all-zero; memories without that need can skip the reset and map to RAM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_addr_q[i] <= '0;
                tbl_data_q[i] <= '0;
            end
        end else if (cfg_we && (state_q != S_RUN) && cfg_ok) begin
            tbl_addr_q[cfg_idx] <= cfg_addr;
            tbl_data_q[cfg_idx] <= cfg_data;
        end
    end

    // State and datapath registers.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge regardless of order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            match_q <= '0;
            cyc_q   <= '0;
            fcode_q <= FC_NONE;
            faddr_q <= '0;
            fdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            match_q <= match_d;
            cyc_q   <= cyc_d;
            fcode_q <= fcode_d;
            faddr_q <= faddr_d;
            fdata_q <= fdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    // Next-state logic.
    // NOTE: every signal gets a hold default before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        match_d = match_q;
        cyc_d   = cyc_q;
        fcode_d = fcode_q;
        faddr_d = faddr_q;
        fdata_d = fdata_q;

        case (state_q)
            S_RUN: begin
                cyc_d = cyc_q + CYCW'(1);
                if (wr && hit_addr && hit_data) begin
                    match_d = match_q + (IDXW+1)'(1);
                    if (match_d == count_q) begin
                        state_d = S_PASS;
                    end
                end else if (wr && in_scratch) begin
                    // Scratch traffic is neither checked nor counted.
                end else if (wr) begin
                    state_d = S_FAIL;
                    fcode_d = hit_addr ? FC_DATA : FC_ADDR;
                    faddr_d = dataadr;
                    fdata_d = writedata;
                end
                // A final match on the timeout edge has already moved us to PASS.
                if ((state_d == S_RUN) && (cyc_q == CYC_LAST)) begin
                    state_d = S_FAIL;
                    fcode_d = FC_TIME;
                end
            end
            default: begin
                if (start) begin
                    count_d = start_cnt;
                    match_d = '0;
                    cyc_d   = '0;
                    fcode_d = FC_NONE;
                    faddr_d = '0;
                    fdata_d = '0;
                    state_d = (start_cnt == '0) ? S_PASS : S_RUN;
                end
            end
        endcase
    end

    // Status flags are decoded from the next state and then registered, so
    // they change on the same edge as the state itself.
    always_comb begin
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_PASS) || (state_d == S_FAIL);
        pass_d = (state_d == S_PASS);
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_code = fcode_q;
    assign match_cnt = match_q;
    assign fail_addr = faddr_q;
    assign fail_data = fdata_q;

endmodule
